// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding fetches to
// instruction memory and presents {PC+PC_INC, instruction} to decode.
// A single buffer entry absorbs a response that lands while decode is stalled.
//
// state | meaning
// IDLE  | out of reset, nothing issued yet
// FETCH | request asserted at pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | response parked in buffer until decode unstalls
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [63:0] IFID,
    output logic        ifid_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_req_q, pc_req_d;
    logic [63:0] ifid_q, ifid_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [63:0] buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_next;

    // Address following the instruction in flight; wraps modulo 2^32.
    assign pc_next = pc_req_q + PC_INC;

    assign imem_req   = (state_q == FETCH) && !redirect;
    assign imem_addr  = pc_q;
    assign IFID       = ifid_q;
    assign ifid_valid = ifid_valid_q;

    // Next-state logic; redirect outranks stall and every other event.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_req_d     = pc_req_q;
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        kill_d       = kill_q;

        if (redirect) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            buf_valid_d  = 1'b0;
            if (state_q == WAIT) begin
                if (imem_rvalid) begin
                    // response is for the old path; drop it and refetch
                    kill_d  = 1'b0;
                    state_d = FETCH;
                end else begin
                    // response still owed; swallow it when it arrives
                    kill_d  = 1'b1;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            // an unstalled edge without a fresh load leaves a bubble
            if (!stall) begin
                ifid_valid_d = 1'b0;
            end
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        pc_req_d = pc_q;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = FETCH;
                        end else if (!stall || !ifid_valid_q) begin
                            ifid_d       = {pc_next, imem_rdata};
                            ifid_valid_d = 1'b1;
                            pc_d         = pc_next;
                            state_d      = FETCH;
                        end else begin
                            buf_d       = {pc_next, imem_rdata};
                            buf_valid_d = 1'b1;
                            pc_d        = pc_next;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_d       = buf_q;
                        ifid_valid_d = 1'b1;
                        buf_valid_d  = 1'b0;
                        state_d      = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pc_req_q     <= RESET_PC;
            ifid_q       <= 64'd0;
            ifid_valid_q <= 1'b0;
            buf_q        <= 64'd0;
            buf_valid_q  <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_req_q     <= pc_req_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            kill_q       <= kill_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each task drives one scenario and checks
// the outputs one time unit after the rising edge.
module tb_if_stage;

    logic        CLK;
    logic        RST_N;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [63:0] IFID;
    logic        ifid_valid;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IFID        (IFID),
        .ifid_valid  (ifid_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #1 RST_N = 1'b0;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (IFID !== 64'd0) begin errors++; $display("FAIL reset_ifid: got %h expected 0", IFID); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        RST_N = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL idle_to_fetch_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_basic_fetch();
        imem_ready = 1'b1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h expected 0", imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b expected 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h2002_0005;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (IFID !== {32'h4, 32'h2002_0005}) begin errors++; $display("FAIL basic_ifid0: got %h expected %h", IFID, {32'h4, 32'h2002_0005}); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b expected 1", ifid_valid); end
        checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL basic_addr1: got %h/%b expected 4/1", imem_addr, imem_req); end
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b expected 0", ifid_valid); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (IFID !== {32'h8, 32'h0000_0020}) begin errors++; $display("FAIL basic_ifid1: got %h expected %h", IFID, {32'h8, 32'h0000_0020}); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1: got %b expected 1", ifid_valid); end
    endtask

    task automatic test_stall();
        // FETCH at pc=8; stall before acceptance so IFID stays valid
        stall = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hAC01_0000;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (IFID !== {32'h8, 32'h0000_0020} || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got %h/%b expected %h/1", i, IFID, ifid_valid, {32'h8, 32'h0000_0020}); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d: got %b expected 0", i, imem_req); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        checks++; if (IFID !== {32'hC, 32'hAC01_0000} || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got %h/%b expected %h/1", IFID, ifid_valid, {32'hC, 32'hAC01_0000}); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next_addr: got %b/%h expected 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdw_wait: got %b expected 0", imem_req); end
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b0) begin errors++; $display("FAIL rdw_kill: got %b/%h/%b expected 0/40/0", ifid_valid, imem_addr, imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (IFID !== {32'hC, 32'hAC01_0000} || ifid_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop: got %h/%b expected %h/0", IFID, ifid_valid, {32'hC, 32'hAC01_0000}); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rdw_refetch: got %b/%h expected 1/40", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_0000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (IFID !== {32'h44, 32'h1111_0000} || ifid_valid !== 1'b1) begin errors++; $display("FAIL rdh_load: got %h/%b expected %h/1", IFID, ifid_valid, {32'h44, 32'h1111_0000}); end
        stall = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_0000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rdh_in_hold: got %b/%b expected 0/1", imem_req, ifid_valid); end
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdh_req_masked: got %b expected 0", imem_req); end
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdh_flush: got %b/%b/%h expected 0/1/100", ifid_valid, imem_req, imem_addr); end
        stall = 1'b0;
    endtask

    task automatic test_ready_low();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_0000;
        tick();
        imem_rvalid = 1'b0;
        imem_ready = 1'b0;
        checks++; if (IFID !== {32'h104, 32'h3333_0000} || ifid_valid !== 1'b1) begin errors++; $display("FAIL rl_load: got %h/%b expected %h/1", IFID, ifid_valid, {32'h104, 32'h3333_0000}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || ifid_valid !== 1'b0) begin errors++; $display("FAIL rl_cycle%0d: got %b/%h/%b expected 1/104/0", i, imem_req, imem_addr, ifid_valid); end
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got %h/%b expected fffffffc/1", imem_addr, imem_req); end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0800_0000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (IFID !== {32'h0, 32'h0800_0000} || ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid: got %h/%b expected %h/1", IFID, ifid_valid, {32'h0, 32'h0800_0000}); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 0", imem_addr); end
        tick();
        #2 RST_N = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || IFID !== 64'd0 || ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL async_reset: got %b/%h/%b/%h expected 0/0/0/0", imem_req, IFID, ifid_valid, imem_addr); end
        tick();
        RST_N = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || IFID !== 64'd0 || imem_req !== 1'b1) begin errors++; $display("FAIL stale_resp: got %b/%h/%b expected 0/0/1", ifid_valid, IFID, imem_req); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_ready_low();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
